power_supervisor_mc: RTL and testbench

//  Multi-channel power supervisor between N INA2xx-class monitor controllers and the SoC power-down pin.

---
 rtl/power_supervisor_mc.sv | 271 +++++++++++++++++++++++++++
 tb/tb_power_supervisor_mc.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_supervisor_mc.sv
`default_nettype none
// ============================================================================
// power_supervisor_mc : ID-gated SoC power enable with per-channel debounced
//                       low-voltage / over-power faults, battery gauge, peak log
// Revision 1.0
// ============================================================================
module power_supervisor_mc #(
    parameter int          N_CH           = 2,
    parameter int          VOLT_W         = 25,
    parameter int          PWR_W          = 16,
    parameter logic [15:0] CHIP_ID        = 16'h2260,
    parameter int          LED_INIT_TICKS = 65535,
    parameter int          LOWBAT_TICKS   = 48000000,
    parameter int          OVERPWR_TICKS  = 4800000,
    parameter int          BAT_LOW        = 4720,
    parameter int          BAT_L2         = 4896,
    parameter int          BAT_L3         = 5080,
    parameter int          HYST           = 8,
    parameter int          AUTO_RETRY     = 0,
    parameter int          RETRY_TICKS    = 24000000
) (
    input  logic                    MAX10_CLK1_24,
    input  logic                    RESET,
    input  logic [16*N_CH-1:0]      die_id,
    input  logic [N_CH-1:0]         sample_valid,
    input  logic [VOLT_W*N_CH-1:0]  bus_voltage,
    input  logic [PWR_W*N_CH-1:0]   power,
    input  logic [PWR_W*N_CH-1:0]   power_limit,
    input  logic                    fault_clear,
    input  logic                    peak_clear,
    output logic                    SOC_SYS_PDN_n,
    output logic                    MAX_WARN_LED,
    output logic [2:0]              BATTERY_LED,
    output logic [N_CH-1:0]         fault_ch,
    output logic [1:0]              fault_type,
    output logic [PWR_W-1:0]        power_max,
    output logic [2:0]              power_max_ch,
    output logic [29:0]             power_max_tick
);

    localparam int LB_W = $clog2(LOWBAT_TICKS + 1);
    localparam int OP_W = $clog2(OVERPWR_TICKS + 1);
    localparam int RT_W = $clog2(RETRY_TICKS + 1);
    localparam int IN_W = $clog2(LED_INIT_TICKS + 1);

    localparam logic [LB_W-1:0]   LB_LAST   = LB_W'(LOWBAT_TICKS - 1);
    localparam logic [OP_W-1:0]   OP_LAST   = OP_W'(OVERPWR_TICKS - 1);
    localparam logic [RT_W-1:0]   RT_LAST   = RT_W'(RETRY_TICKS - 1);
    localparam logic [IN_W-1:0]   INIT_LAST = IN_W'(LED_INIT_TICKS - 1);

    localparam logic [VOLT_W-1:0] V_LOW    = VOLT_W'(BAT_LOW);
    localparam logic [VOLT_W-1:0] V_L2     = VOLT_W'(BAT_L2);
    localparam logic [VOLT_W-1:0] V_L3     = VOLT_W'(BAT_L3);
    localparam logic [VOLT_W-1:0] V_LOW_DN = VOLT_W'(BAT_LOW - HYST);
    localparam logic [VOLT_W-1:0] V_L2_DN  = VOLT_W'(BAT_L2 - HYST);
    localparam logic [VOLT_W-1:0] V_L3_DN  = VOLT_W'(BAT_L3 - HYST);

    typedef enum logic [1:0] {
        S_WAIT_ID = 2'd0,
        S_INIT    = 2'd1,
        S_RUN     = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    state_t            state_q;
    logic [IN_W-1:0]   init_cnt_q;
    logic [RT_W-1:0]   retry_cnt_q;
    logic [1:0]        level_q;
    logic [1:0]        level_d;
    logic              pdn_q;
    logic              warn_q;
    logic [2:0]        led_q;
    logic [N_CH-1:0]   fault_ch_q;
    logic [1:0]        fault_type_q;
    logic [29:0]       tick_q;
    logic [PWR_W-1:0]  peak_q;
    logic [PWR_W-1:0]  peak_d;
    logic [2:0]        peak_ch_q;
    logic [2:0]        peak_ch_d;
    logic [29:0]       peak_tick_q;
    logic [29:0]       peak_tick_d;

    logic              w_active;
    logic [N_CH-1:0]   w_id_ok;
    logic [N_CH-1:0]   w_low_v;
    logic [N_CH-1:0]   w_over_p;
    logic [N_CH-1:0]   w_lb_fire;
    logic [N_CH-1:0]   w_op_fire;
    logic              w_any_cond;
    logic              w_recover;
    logic [VOLT_W-1:0] w_v0;
    logic [1:0]        w_up_lvl;
    logic [VOLT_W-1:0] w_dn_thr;
    logic [2:0]        w_led_run;
    logic [2:0]        w_led_hold;

    assign w_active = (state_q == S_INIT) || (state_q == S_RUN);

    // Debounce counters only run while powered; FAULT and WAIT_ID hold them at 0.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [VOLT_W-1:0] volt_q;
        logic [PWR_W-1:0]  pwr_q;
        logic [LB_W-1:0]   lb_cnt_q;
        logic [OP_W-1:0]   op_cnt_q;

        assign w_id_ok[c]   = (die_id[16*c +: 16] == CHIP_ID);
        assign w_low_v[c]   = (volt_q < V_LOW);
        assign w_over_p[c]  = (pwr_q > power_limit[PWR_W*c +: PWR_W]);
        assign w_lb_fire[c] = w_active && w_low_v[c] && (lb_cnt_q == LB_LAST);
        assign w_op_fire[c] = w_active && w_over_p[c] && (op_cnt_q == OP_LAST);

        always_ff @(posedge MAX10_CLK1_24) begin
            if (RESET) begin
                volt_q   <= '0;
                pwr_q    <= '0;
                lb_cnt_q <= '0;
                op_cnt_q <= '0;
            end else begin
                if (sample_valid[c]) begin
                    volt_q <= bus_voltage[VOLT_W*c +: VOLT_W];
                    pwr_q  <= power[PWR_W*c +: PWR_W];
                end
                if (!w_active || !w_low_v[c]) begin
                    lb_cnt_q <= '0;
                end else begin
                    lb_cnt_q <= lb_cnt_q + 1'b1;
                end
                if (!w_active || !w_over_p[c]) begin
                    op_cnt_q <= '0;
                end else begin
                    op_cnt_q <= op_cnt_q + 1'b1;
                end
            end
        end
    end

    assign w_v0       = g_ch[0].volt_q;
    assign w_any_cond = (|w_low_v) || (|w_over_p);
    assign w_recover  = (AUTO_RETRY != 0) ? (!w_any_cond && (retry_cnt_q == RT_LAST))
                                          : (fault_clear && !w_any_cond);

    // Rising uses the plain thresholds; falling requires V to clear the current
    // level's threshold minus HYST, then lands on whatever level V supports.
    always_comb begin
        w_up_lvl = 2'd0;
        if (w_v0 > V_L3) begin
            w_up_lvl = 2'd3;
        end else if (w_v0 > V_L2) begin
            w_up_lvl = 2'd2;
        end else if (w_v0 > V_LOW) begin
            w_up_lvl = 2'd1;
        end
        case (level_q)
            2'd1:    w_dn_thr = V_LOW_DN;
            2'd2:    w_dn_thr = V_L2_DN;
            2'd3:    w_dn_thr = V_L3_DN;
            default: w_dn_thr = '0;
        endcase
        level_d = level_q;
        if (w_up_lvl > level_q) begin
            level_d = w_up_lvl;
        end else if ((level_q != 2'd0) && (w_v0 <= w_dn_thr)) begin
            level_d = w_up_lvl;
        end
    end

    assign w_led_run  = 3'b111 >> (2'd3 - level_d);
    assign w_led_hold = 3'b111 >> (2'd3 - level_q);

    // Strict '>' while scanning upward keeps the lowest index on ties.
    always_comb begin
        peak_d      = peak_clear ? '0 : peak_q;
        peak_ch_d   = peak_clear ? '0 : peak_ch_q;
        peak_tick_d = peak_clear ? '0 : peak_tick_q;
        if (w_active) begin
            for (int c = 0; c < N_CH; c++) begin
                if (sample_valid[c] && (power[PWR_W*c +: PWR_W] > peak_d)) begin
                    peak_d      = power[PWR_W*c +: PWR_W];
                    peak_ch_d   = 3'(c);
                    peak_tick_d = tick_q;
                end
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_24) begin
        if (RESET) begin
            tick_q      <= '0;
            peak_q      <= '0;
            peak_ch_q   <= '0;
            peak_tick_q <= '0;
        end else begin
            tick_q      <= (&tick_q) ? tick_q : tick_q + 1'b1;
            peak_q      <= peak_d;
            peak_ch_q   <= peak_ch_d;
            peak_tick_q <= peak_tick_d;
        end
    end

    always_ff @(posedge MAX10_CLK1_24) begin
        if (RESET) begin
            state_q      <= S_WAIT_ID;
            init_cnt_q   <= '0;
            retry_cnt_q  <= '0;
            level_q      <= '0;
            pdn_q        <= 1'b0;
            warn_q       <= 1'b0;
            led_q        <= 3'b000;
            fault_ch_q   <= '0;
            fault_type_q <= 2'b00;
        end else begin
            case (state_q)
                S_WAIT_ID: begin
                    if (&w_id_ok) begin
                        state_q    <= S_INIT;
                        init_cnt_q <= '0;
                        pdn_q      <= 1'b1;
                        warn_q     <= 1'b1;
                        led_q      <= 3'b111;
                    end
                end
                S_INIT, S_RUN: begin
                    level_q <= level_d;
                    if (|(w_lb_fire | w_op_fire)) begin
                        state_q      <= S_FAULT;
                        retry_cnt_q  <= '0;
                        pdn_q        <= 1'b0;
                        warn_q       <= 1'b1;
                        led_q        <= 3'b000;
                        fault_ch_q   <= fault_ch_q | w_lb_fire | w_op_fire;
                        fault_type_q <= fault_type_q | {|w_op_fire, |w_lb_fire};
                    end else if ((state_q == S_INIT) && (init_cnt_q != INIT_LAST)) begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end else begin
                        state_q <= S_RUN;
                        pdn_q   <= 1'b1;
                        warn_q  <= 1'b0;
                        led_q   <= w_led_run;
                    end
                end
                S_FAULT: begin
                    if (w_recover) begin
                        state_q      <= S_RUN;
                        retry_cnt_q  <= '0;
                        pdn_q        <= 1'b1;
                        warn_q       <= 1'b0;
                        led_q        <= w_led_hold;
                        fault_ch_q   <= '0;
                        fault_type_q <= 2'b00;
                    end else if (w_any_cond || (AUTO_RETRY == 0)) begin
                        retry_cnt_q <= '0;
                    end else begin
                        retry_cnt_q <= retry_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_WAIT_ID;
            endcase
        end
    end

    assign SOC_SYS_PDN_n  = pdn_q;
    assign MAX_WARN_LED   = warn_q;
    assign BATTERY_LED    = led_q;
    assign fault_ch       = fault_ch_q;
    assign fault_type     = fault_type_q;
    assign power_max      = peak_q;
    assign power_max_ch   = peak_ch_q;
    assign power_max_tick = peak_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_power_supervisor_mc.sv
`default_nettype none
// ============================================================================
// tb_power_supervisor_mc : directed bench for power_supervisor_mc (latched and
//                          auto-retry instances driven from shared stimulus)
// Revision 1.0
// ============================================================================
module tb_power_supervisor_mc;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] die_id = {16'h2260, 16'h2260};
    logic [1:0]  sample_valid = 2'b00;
    logic [49:0] bus_voltage = '0;
    logic [31:0] power = '0;
    logic [31:0] power_limit = {16'd2600, 16'd2600};
    logic        fault_clear = 1'b0;
    logic        peak_clear = 1'b0;

    logic        pdn, warn, pdn_b, warn_b;
    logic [2:0]  led, led_b;
    logic [1:0]  fch, ftype, fch_b, ftype_b;
    logic [15:0] pmax, pmax_b;
    logic [2:0]  pmax_ch, pmax_ch_b;
    logic [29:0] pmax_tick, pmax_tick_b;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [29:0] cyc = '0;
    logic [29:0] exp_tick;

    always #5 clk = ~clk;

    // Elapsed cycles since reset release: the reference for captured timestamps.
    always @(posedge clk) begin
        if (RESET) cyc <= '0;
        else       cyc <= cyc + 30'd1;
    end

    power_supervisor_mc #(
        .N_CH(2), .LED_INIT_TICKS(4), .LOWBAT_TICKS(10), .OVERPWR_TICKS(5),
        .AUTO_RETRY(0), .RETRY_TICKS(8)
    ) dut (
        .MAX10_CLK1_24(clk), .RESET(RESET), .die_id(die_id),
        .sample_valid(sample_valid), .bus_voltage(bus_voltage), .power(power),
        .power_limit(power_limit), .fault_clear(fault_clear), .peak_clear(peak_clear),
        .SOC_SYS_PDN_n(pdn), .MAX_WARN_LED(warn), .BATTERY_LED(led),
        .fault_ch(fch), .fault_type(ftype), .power_max(pmax),
        .power_max_ch(pmax_ch), .power_max_tick(pmax_tick)
    );

    power_supervisor_mc #(
        .N_CH(2), .LED_INIT_TICKS(4), .LOWBAT_TICKS(10), .OVERPWR_TICKS(5),
        .AUTO_RETRY(1), .RETRY_TICKS(8)
    ) dut_ar (
        .MAX10_CLK1_24(clk), .RESET(RESET), .die_id(die_id),
        .sample_valid(sample_valid), .bus_voltage(bus_voltage), .power(power),
        .power_limit(power_limit), .fault_clear(fault_clear), .peak_clear(peak_clear),
        .SOC_SYS_PDN_n(pdn_b), .MAX_WARN_LED(warn_b), .BATTERY_LED(led_b),
        .fault_ch(fch_b), .fault_type(ftype_b), .power_max(pmax_b),
        .power_max_ch(pmax_ch_b), .power_max_tick(pmax_tick_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [24:0] v, input logic [15:0] p);
        bus_voltage[25*ch +: 25] = v;
        power[16*ch +: 16] = p;
        sample_valid = 2'b00;
        sample_valid[ch] = 1'b1;
        tick();
        sample_valid = 2'b00;
    endtask

    task automatic send2(input logic [24:0] v0, input logic [15:0] p0,
                         input logic [24:0] v1, input logic [15:0] p1);
        bus_voltage = {v1, v0};
        power = {p1, p0};
        sample_valid = 2'b11;
        tick();
        sample_valid = 2'b00;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        sample_valid = 2'b00;
        fault_clear = 1'b0;
        peak_clear = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic bring_up();
        apply_reset();
        die_id = {16'h2260, 16'h2260};
        power_limit = {16'd2600, 16'd2600};
        send2(25'd5000, 16'd100, 25'd5000, 16'd100);
        repeat (6) tick();
    endtask

    task automatic test_reset();
        die_id = {16'h2261, 16'h2260};
        apply_reset();
        n_checks++;
        if ({pdn, warn, led, fch, ftype} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pdn=%b warn=%b led=%b fch=%b ftype=%b, want all 0",
                     pdn, warn, led, fch, ftype);
        end
        n_checks++;
        if ({pmax, pmax_ch, pmax_tick} !== 49'b0) begin
            n_fail++;
            $display("FAIL reset_peak: got max=%0d ch=%0d tick=%0d, want 0/0/0", pmax, pmax_ch, pmax_tick);
        end
    endtask

    task automatic test_id_gating();
        send2(25'd5000, 16'd100, 25'd5000, 16'd100);
        repeat (4) tick();
        n_checks++;
        if (pdn !== 1'b0) begin
            n_fail++;
            $display("FAIL id_mismatch_pdn: got %b want 0", pdn);
        end
        die_id = {16'h2260, 16'h2260};
        tick();
        n_checks++;
        if ({pdn, warn, led} !== 5'b11111) begin
            n_fail++;
            $display("FAIL id_match_init: got pdn=%b warn=%b led=%b want 1 1 111", pdn, warn, led);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            n_checks++;
            if ({pdn, warn, led} !== 5'b11111) begin
                n_fail++;
                $display("FAIL init_hold_%0d: got pdn=%b warn=%b led=%b want 1 1 111", i, pdn, warn, led);
            end
        end
        tick();
        n_checks++;
        if ({pdn, warn, led} !== 5'b10011) begin
            n_fail++;
            $display("FAIL run_entry: got pdn=%b warn=%b led=%b want 1 0 011", pdn, warn, led);
        end
        die_id = {16'h2261, 16'h2260};
        repeat (2) tick();
        n_checks++;
        if (pdn !== 1'b1) begin
            n_fail++;
            $display("FAIL id_change_in_run: got pdn=%b want 1", pdn);
        end
    endtask

    task automatic test_low_battery();
        bring_up();
        send(0, 25'd4700, 16'd100);
        repeat (8) tick();
        send(0, 25'd5000, 16'd100);
        repeat (3) tick();
        n_checks++;
        if ({pdn, ftype} !== 3'b100) begin
            n_fail++;
            $display("FAIL lowbat_9cyc: got pdn=%b ftype=%b want 1 00", pdn, ftype);
        end
        send(0, 25'd4700, 16'd100);
        repeat (9) tick();
        n_checks++;
        if (pdn !== 1'b1) begin
            n_fail++;
            $display("FAIL lowbat_before_10: got pdn=%b want 1", pdn);
        end
        tick();
        n_checks++;
        if ({pdn, warn, led, ftype, fch} !== 9'b0_1_000_01_01) begin
            n_fail++;
            $display("FAIL lowbat_fault: got pdn=%b warn=%b led=%b ftype=%b fch=%b want 0 1 000 01 01",
                     pdn, warn, led, ftype, fch);
        end
        send(1, 25'd5000, 16'd2601);
        repeat (7) tick();
        n_checks++;
        if ({pdn, ftype, fch} !== 5'b0_01_01) begin
            n_fail++;
            $display("FAIL fault_frozen: got pdn=%b ftype=%b fch=%b want 0 01 01", pdn, ftype, fch);
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        n_checks++;
        if ({pdn, warn, led, fch, ftype} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_in_fault: got pdn=%b warn=%b led=%b fch=%b ftype=%b want all 0",
                     pdn, warn, led, fch, ftype);
        end
    endtask

    task automatic test_over_power();
        bring_up();
        send(1, 25'd5000, 16'd2601);
        repeat (4) tick();
        n_checks++;
        if (pdn !== 1'b1) begin
            n_fail++;
            $display("FAIL overp_before_5: got pdn=%b want 1", pdn);
        end
        tick();
        n_checks++;
        if ({pdn, fch, ftype} !== 5'b0_10_10) begin
            n_fail++;
            $display("FAIL overp_fault: got pdn=%b fch=%b ftype=%b want 0 10 10", pdn, fch, ftype);
        end
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        tick();
        n_checks++;
        if (pdn !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_while_active: got pdn=%b want 0", pdn);
        end
        send(1, 25'd5000, 16'd100);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        n_checks++;
        if ({pdn, warn, led, fch, ftype} !== 9'b1_0_011_00_00) begin
            n_fail++;
            $display("FAIL clear_recover: got pdn=%b warn=%b led=%b fch=%b ftype=%b want 1 0 011 00 00",
                     pdn, warn, led, fch, ftype);
        end
    endtask

    task automatic test_auto_retry();
        bring_up();
        send(0, 25'd5000, 16'd2601);
        repeat (5) tick();
        n_checks++;
        if ({pdn_b, fch_b, ftype_b} !== 5'b0_01_10) begin
            n_fail++;
            $display("FAIL ar_fault: got pdn=%b fch=%b ftype=%b want 0 01 10", pdn_b, fch_b, ftype_b);
        end
        send(0, 25'd5000, 16'd100);
        repeat (5) tick();
        send(0, 25'd5000, 16'd2601);
        send(0, 25'd5000, 16'd100);
        for (int i = 1; i < 8; i++) begin
            tick();
            n_checks++;
            if (pdn_b !== 1'b0) begin
                n_fail++;
                $display("FAIL ar_restart_cyc%0d: got pdn=%b want 0", i, pdn_b);
            end
        end
        tick();
        n_checks++;
        if ({pdn_b, warn_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL ar_recover: got pdn=%b warn=%b want 1 0", pdn_b, warn_b);
        end
        n_checks++;
        if (pdn !== 1'b0) begin
            n_fail++;
            $display("FAIL latched_no_retry: got pdn=%b want 0", pdn);
        end
    endtask

    task automatic test_gauge();
        logic [24:0] vv [7];
        logic [2:0]  ll [7];
        bring_up();
        vv = '{25'd5100, 25'd5075, 25'd5072, 25'd4889, 25'd4888, 25'd5100, 25'd4800};
        ll = '{3'b111,   3'b111,   3'b011,   3'b011,   3'b001,   3'b111,   3'b001};
        for (int i = 0; i < 7; i++) begin
            send(0, vv[i], 16'd100);
            tick();
            n_checks++;
            if (led !== ll[i]) begin
                n_fail++;
                $display("FAIL gauge_v%0d: got led=%b want %b", vv[i], led, ll[i]);
            end
        end
    endtask

    task automatic test_peak();
        bring_up();
        power_limit = {16'd5000, 16'd5000};
        n_checks++;
        if (pmax !== 16'd0) begin
            n_fail++;
            $display("FAIL peak_initial: got %0d want 0", pmax);
        end
        exp_tick = cyc;
        send2(25'd5000, 16'd3000, 25'd5000, 16'd3000);
        n_checks++;
        if ({pmax, pmax_ch, pmax_tick} !== {16'd3000, 3'd0, exp_tick}) begin
            n_fail++;
            $display("FAIL peak_tie: got max=%0d ch=%0d tick=%0d want 3000 0 %0d", pmax, pmax_ch, pmax_tick, exp_tick);
        end
        repeat (3) tick();
        send(1, 25'd5000, 16'd3000);
        n_checks++;
        if ({pmax, pmax_ch, pmax_tick} !== {16'd3000, 3'd0, exp_tick}) begin
            n_fail++;
            $display("FAIL peak_equal_no_update: got max=%0d ch=%0d tick=%0d want 3000 0 %0d",
                     pmax, pmax_ch, pmax_tick, exp_tick);
        end
        exp_tick = cyc;
        send(1, 25'd5000, 16'd3001);
        n_checks++;
        if ({pmax, pmax_ch, pmax_tick} !== {16'd3001, 3'd1, exp_tick}) begin
            n_fail++;
            $display("FAIL peak_update: got max=%0d ch=%0d tick=%0d want 3001 1 %0d", pmax, pmax_ch, pmax_tick, exp_tick);
        end
        peak_clear = 1'b1;
        tick();
        peak_clear = 1'b0;
        n_checks++;
        if ({pmax, pmax_ch, pmax_tick} !== 49'b0) begin
            n_fail++;
            $display("FAIL peak_clear: got max=%0d ch=%0d tick=%0d want 0 0 0", pmax, pmax_ch, pmax_tick);
        end
        exp_tick = cyc;
        peak_clear = 1'b1;
        send2(25'd5000, 16'd40, 25'd5000, 16'd50);
        peak_clear = 1'b0;
        n_checks++;
        if ({pmax, pmax_ch, pmax_tick} !== {16'd50, 3'd1, exp_tick}) begin
            n_fail++;
            $display("FAIL peak_clear_same_cycle: got max=%0d ch=%0d tick=%0d want 50 1 %0d",
                     pmax, pmax_ch, pmax_tick, exp_tick);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_id_gating();
        test_low_battery();
        test_over_power();
        test_auto_retry();
        test_gauge();
        test_peak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
